// File: rtl/fixed_mult_arbiter.sv
// Round-robin front end sharing one fixed-point multiplier among N_REQ requesters.
// Two-stage pipeline (operands, product); results come back tagged with the requester id.
module fixed_mult_arbiter #(
  parameter int N_REQ           = 4,
  parameter int fractional_size = 12,
  parameter int operand_size    = 32,
  parameter int expansion_size  = operand_size,
  parameter int ID_W            = $clog2(N_REQ)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [N_REQ-1:0]                          req_valid,
  output logic [N_REQ-1:0]                          req_ready,
  input  logic [N_REQ*operand_size-1:0]             req_a,
  input  logic [N_REQ*operand_size-1:0]             req_b,
  output logic                                      rsp_valid,
  output logic [ID_W-1:0]                           rsp_id,
  output logic [operand_size+expansion_size-1:0]    rsp_data,
  output logic                                      busy
);

  localparam int OW    = operand_size;
  localparam int RES_W = operand_size + expansion_size;
  localparam int PW    = 2 * operand_size;

  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic                    s1_valid_q, s1_valid_d;
  logic signed [OW-1:0]    s1_a_q, s1_a_d;
  logic signed [OW-1:0]    s1_b_q, s1_b_d;
  logic [ID_W-1:0]         s1_id_q, s1_id_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]         s2_id_q, s2_id_d;
  logic [RES_W-1:0]        s2_data_q, s2_data_d;

  logic                    gnt_found;
  logic [ID_W-1:0]         gnt_id;
  logic signed [PW-1:0]    prod;

  function automatic int wrap(input int p, input int k);
    return (p + k) % N_REQ;
  endfunction

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!gnt_found && req_valid[wrap(int'(ptr_q), k)]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(wrap(int'(ptr_q), k));
      end
    end
    if (gnt_found) req_ready[gnt_id] = 1'b1;
  end

  assign prod = s1_a_q * s1_b_q;

  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = gnt_found;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s1_valid_q;
    s2_id_d    = s2_id_q;
    s2_data_d  = s2_data_q;
    if (gnt_found) begin
      ptr_d   = gnt_id;
      s1_a_d  = req_a[int'(gnt_id)*OW +: OW];
      s1_b_d  = req_b[int'(gnt_id)*OW +: OW];
      s1_id_d = gnt_id;
    end
    // Product regs only load on a real result so rsp_* hold when idle.
    if (s1_valid_q) begin
      s2_id_d   = s1_id_q;
      s2_data_d = RES_W'(prod >>> fractional_size);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= ID_W'(N_REQ - 1);
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_id    = s2_id_q;
  assign rsp_data  = s2_data_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_fixed_mult_arbiter.sv
// Randomized and directed bench for fixed_mult_arbiter.
// Reference: grant scan plus a queue of expected results with due cycles.
module tb_fixed_mult_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_data;
  logic         busy;

  fixed_mult_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  int          mptr;
  int          cyc;
  logic [1:0]  last_id;
  logic [63:0] last_data;
  int          nchk;
  int          nfail;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return (sa * sb) >>> 12;
  endfunction

  function automatic logic [127:0] put(input logic [127:0] f, input int i,
                                       input logic [31:0] v);
    logic [127:0] r;
    r = f;
    r[i*32 +: 32] = v;
    return r;
  endfunction

  // One clock: drive, check at negedge, advance model after posedge.
  task automatic cycle(input logic [3:0] v, input logic [127:0] fa,
                       input logic [127:0] fb, output logic [3:0] rdy,
                       output int g);
    logic [3:0] exp_rdy;
    logic       exp_busy;
    req_valid = v;
    req_a     = fa;
    req_b     = fb;
    @(negedge clk);
    g = -1;
    for (int k = 1; k <= 4; k++)
      if (g < 0 && v[(mptr + k) % 4]) g = (mptr + k) % 4;
    exp_rdy = (g < 0) ? 4'b0 : 4'(1 << g);
    rdy = req_ready;
    chk("ready", {60'b0, req_ready}, {60'b0, exp_rdy});
    exp_busy = (q.size() != 0);
    chk("busy", {63'b0, busy}, {63'b0, exp_busy});
    if (q.size() != 0 && q[0].due == cyc) begin
      chk("rsp_valid", {63'b0, rsp_valid}, 64'd1);
      chk("rsp_id", {62'b0, rsp_id}, {62'b0, q[0].id});
      chk("rsp_data", rsp_data, q[0].data);
      last_id   = q[0].id;
      last_data = q[0].data;
      void'(q.pop_front());
    end else begin
      chk("rsp_idle", {63'b0, rsp_valid}, 64'd0);
      chk("rsp_id_hold", {62'b0, rsp_id}, {62'b0, last_id});
      chk("rsp_data_hold", rsp_data, last_data);
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      q.push_back('{due: cyc + 2, id: 2'(g),
                    data: ref_mul(fa[g*32 +: 32], fb[g*32 +: 32])});
      mptr = g;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    q.delete();
    mptr      = 3;
    last_id   = '0;
    last_data = '0;
    @(negedge clk);
    chk("rst_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rst_id", {62'b0, rsp_id}, 64'd0);
    chk("rst_data", rsp_data, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  task automatic idle(input int n);
    logic [3:0] r;
    int         g;
    for (int i = 0; i < n; i++) cycle(4'b0, '0, '0, r, g);
  endtask

  task automatic op(input int i, input logic [31:0] a, input logic [31:0] b,
                    input logic [63:0] exp, input string tag);
    logic [3:0] r;
    int         g;
    cycle(4'(1 << i), put('0, i, a), put('0, i, b), r, g);
    chk({tag, "_grant"}, {60'b0, r}, {60'b0, 4'(1 << i)});
    idle(3);
    chk({tag, "_id"}, {62'b0, rsp_id}, 64'(i));
    chk({tag, "_data"}, rsp_data, exp);
  endtask

  logic [3:0]   rdy;
  int           g;
  logic [3:0]   pv;
  logic [127:0] fa, fb;

  initial begin
    nchk = 0;
    nfail = 0;
    cyc = 0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    op(2, 32'd8192, 32'd6144, 64'd12288, "t1");
    op(0, -32'sd4096, 32'd2048, -64'sd2048, "t2a");
    op(1, 32'hFFFF_FFFF, 32'd1, -64'sd1, "t2b");
    op(3, 32'd1, 32'd1, 64'd0, "t2c");

    fa = '0;
    fb = '0;
    for (int i = 0; i < 4; i++) begin
      fa = put(fa, i, 32'(4096 * (i + 1)));
      fb = put(fb, i, 32'(-8192 + i));
    end
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(4'hF, fa, fb, rdy, g);
      chk("rr_grant", {60'b0, rdy}, {60'b0, 4'(1 << (k % 4))});
    end
    idle(3);

    cycle(4'b0010, fa, fb, rdy, g);
    chk("pri_g1", {60'b0, rdy}, 64'b0010);
    cycle(4'b1001, fa, fb, rdy, g);
    chk("pri_g3", {60'b0, rdy}, 64'b1000);
    cycle(4'b0001, fa, fb, rdy, g);
    chk("pri_g0", {60'b0, rdy}, 64'b0001);
    idle(3);

    cycle(4'b0100, fa, fb, rdy, g);
    do_reset();
    idle(3);
    cycle(4'hF, fa, fb, rdy, g);
    chk("post_rst_g0", {60'b0, rdy}, 64'b0001);
    idle(3);

    op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h0003_FFFF_FFF0_0000, "max");
    op(1, 32'h8000_0000, 32'h8000_0000, 64'h0004_0000_0000_0000, "min");

    pv = '0;
    fa = '0;
    fb = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          if ($urandom_range(0, 2) == 0) begin
            fa = put(fa, i, $urandom);
            fb = put(fb, i, $urandom);
          end else begin
            fa = put(fa, i, 32'($urandom_range(0, 65535)) - 32'd32768);
            fb = put(fb, i, 32'($urandom_range(0, 65535)) - 32'd32768);
          end
        end else if (pv[i] && $urandom_range(0, 15) == 0) begin
          pv[i] = 1'b0;
        end
      end
      cycle(pv, fa, fb, rdy, g);
      if (g >= 0) pv[g] = 1'b0;
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
